time_keeper: RTL and testbench



---
 rtl/time_keeper_pkg.sv | 72 +++++++
 rtl/time_keeper_button_debounce.sv | 45 ++++
 rtl/time_keeper.sv | 138 +++++++++++++
 tb/tb_time_keeper.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared types, digit indices and BCD field helpers for the time_keeper timebase.
package time_keeper_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } set_mode_t;

   typedef logic [3:0] bcd_t;

   // Digit positions inside time_bcd / blank (5 = hour tens)
   localparam int unsigned HT = 5;
   localparam int unsigned HU = 4;
   localparam int unsigned MT = 3;
   localparam int unsigned MU = 2;
   localparam int unsigned ST = 1;
   localparam int unsigned SU = 0;

   localparam logic [7:0] HOUR_LIMIT   = 8'h23;
   localparam logic [7:0] MINSEC_LIMIT = 8'h59;

   // Two-digit BCD increment for minutes/seconds, 59 wraps to 00
   function automatic logic [7:0] inc_sixty(input logic [7:0] f);
      bcd_t tens;
      bcd_t units;
      tens  = f[7:4];
      units = f[3:0];
      if (f == MINSEC_LIMIT)   return 8'h00;
      else if (units == 4'd9)  return {bcd_t'(tens + 4'd1), 4'd0};
      else                     return {tens, bcd_t'(units + 4'd1)};
   endfunction

   // Two-digit BCD increment for hours, 23 wraps to 00
   function automatic logic [7:0] inc_hour(input logic [7:0] f);
      bcd_t tens;
      bcd_t units;
      tens  = f[7:4];
      units = f[3:0];
      if (f == HOUR_LIMIT)     return 8'h00;
      else if (units == 4'd9)  return {bcd_t'(tens + 4'd1), 4'd0};
      else                     return {tens, bcd_t'(units + 4'd1)};
   endfunction

   // One-second advance of HH:MM:SS with carry into the next field
   function automatic logic [23:0] tick_time(input logic [23:0] t);
      logic [23:0] r;
      r       = t;
      r[7:0]  = inc_sixty(t[7:0]);
      if (t[7:0] == MINSEC_LIMIT) begin
         r[15:8] = inc_sixty(t[15:8]);
         if (t[15:8] == MINSEC_LIMIT)
            r[23:16] = inc_hour(t[23:16]);
      end
      return r;
   endfunction

   // Blank bits covering the field edited in a given mode
   function automatic logic [5:0] field_mask(input set_mode_t m);
      logic [5:0] mask;
      mask = '0;
      case (m)
         SET_H:   begin mask[HT] = 1'b1; mask[HU] = 1'b1; end
         SET_M:   begin mask[MT] = 1'b1; mask[MU] = 1'b1; end
         SET_S:   begin mask[ST] = 1'b1; mask[SU] = 1'b1; end
         default: mask = '0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/time_keeper_button_debounce.sv
// Button conditioning: 2-flop synchroniser, stable-level counter, one-cycle press pulse.
module button_debounce
   import time_keeper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // Accept the synchronised level once it has differed from the stable level long enough
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= sync2;
            press  <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/time_keeper.sv
// HH:MM:SS BCD timebase with two-button time setting and an LCD update strobe.
// Optional digit blinking while setting is enabled by defining TIME_KEEPER_BLINK_EN.
module time_keeper
   import time_keeper_pkg::*;
#(
   parameter int unsigned CLOCK_RATE      = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_mode,
   input  logic        btn_inc,
   output logic [23:0] time_bcd,
   output logic        update,
   output logic [1:0]  set_mode,
   output logic [5:0]  blank
);

   localparam int unsigned DIV_W = (CLOCK_RATE > 1) ? $clog2(CLOCK_RATE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_RATE - 1);

   logic             mode_press;
   logic             inc_press;
   set_mode_t        mode;
   set_mode_t        mode_nxt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_nxt;
   logic [23:0]      time_nxt;
   logic             update_nxt;
   logic [5:0]       blank_nxt;

`ifdef TIME_KEEPER_BLINK_EN
   localparam int unsigned HALF    = (CLOCK_RATE / 2 > 0) ? CLOCK_RATE / 2 : 1;
   localparam int unsigned BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic [BLINK_W-1:0] blink_cnt_nxt;
   logic               phase;
   logic               phase_nxt;
`endif

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_mode),
      .press (mode_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_inc),
      .press (inc_press)
   );

   assign set_mode = mode;

   // Next mode, time, divider, strobe and blank; mode press beats inc press
   always_comb begin
      mode_nxt   = mode;
      time_nxt   = time_bcd;
      div_nxt    = div;
      update_nxt = 1'b0;
      blank_nxt  = '0;

      if (mode_press) begin
         case (mode)
            RUN:     mode_nxt = SET_H;
            SET_H:   mode_nxt = SET_M;
            SET_M:   mode_nxt = SET_S;
            default: mode_nxt = RUN;
         endcase
         div_nxt    = '0;
         update_nxt = 1'b1;
      end else if (mode == RUN) begin
         if (div == DIV_LAST) begin
            div_nxt    = '0;
            time_nxt   = tick_time(time_bcd);
            update_nxt = 1'b1;
         end else begin
            div_nxt = div + DIV_W'(1);
         end
      end else begin
         div_nxt = '0;
         if (inc_press) begin
            case (mode)
               SET_H:   time_nxt[23:16] = inc_hour(time_bcd[23:16]);
               SET_M:   time_nxt[15:8]  = inc_sixty(time_bcd[15:8]);
               SET_S:   time_nxt[7:0]   = inc_sixty(time_bcd[7:0]);
               default: time_nxt        = time_bcd;
            endcase
            update_nxt = 1'b1;
         end
      end

`ifdef TIME_KEEPER_BLINK_EN
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b0;
      if (mode != RUN && !mode_press && !inc_press) begin
         if (blink_cnt == BLINK_LAST) begin
            phase_nxt  = ~phase;
            update_nxt = 1'b1;
         end else begin
            blink_cnt_nxt = blink_cnt + BLINK_W'(1);
            phase_nxt     = phase;
         end
      end
      blank_nxt = phase_nxt ? field_mask(mode_nxt) : 6'b0;
`endif
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         mode     <= RUN;
         time_bcd <= '0;
         div      <= '0;
         update   <= 1'b0;
         blank    <= '0;
`ifdef TIME_KEEPER_BLINK_EN
         blink_cnt <= '0;
         phase     <= 1'b0;
`endif
      end else begin
         mode     <= mode_nxt;
         time_bcd <= time_nxt;
         div      <= div_nxt;
         update   <= update_nxt;
         blank    <= blank_nxt;
`ifdef TIME_KEEPER_BLINK_EN
         blink_cnt <= blink_cnt_nxt;
         phase     <= phase_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLOCK_RATE=10, DEBOUNCE_CYCLES=3.
module tb_time_keeper;

   localparam int unsigned CR = 10;
   localparam int unsigned DB = 3;

   logic        clk;
   logic        reset;
   logic        btn_mode;
   logic        btn_inc;
   logic [23:0] time_bcd;
   logic        update;
   logic [1:0]  set_mode;
   logic [5:0]  blank;

   int n_tests = 0;
   int n_fail  = 0;
   int upd_cnt = 0;
   int u0;

   time_keeper #(.CLOCK_RATE(CR), .DEBOUNCE_CYCLES(DB)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .time_bcd (time_bcd),
      .update   (update),
      .set_mode (set_mode),
      .blank    (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count update pulses away from the active edge
   always @(negedge clk) if (!reset && update) upd_cnt++;

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the chosen buttons 6 cycles, release and let the release settle
   task automatic press(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      cycles(6);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cycles(6);
   endtask

   task automatic press_n(input logic m, input logic i, input int n);
      for (int k = 0; k < n; k++) press(m, i);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cycles(3);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cycles(3);
      check("reset_time",   time_bcd,        24'h000000);
      check("reset_update", 24'(update),     24'd0);
      check("reset_mode",   24'(set_mode),   24'd0);
      check("reset_blank",  24'(blank),      24'd0);
      reset = 1'b0;

      // Free-running seconds
      cycles(9);
      check("run_c9_time",  time_bcd,    24'h000000);
      check("run_c9_upd",   24'(update), 24'd0);
      cycles(1);
      check("run_c10_time", time_bcd,    24'h000001);
      check("run_c10_upd",  24'(update), 24'd1);
      cycles(10);
      check("run_c20_time", time_bcd,    24'h000002);
      check("run_c20_upd",  24'(update), 24'd1);
      cycles(5);
      check("run_c25_time", time_bcd,    24'h000002);
      check("run_c25_cnt",  24'(upd_cnt), 24'd2);

      // Short bounce is rejected, a proper hold is accepted
      do_reset();
      btn_mode = 1'b1;
      cycles(2);
      btn_mode = 1'b0;
      cycles(8);
      check("bounce_mode", 24'(set_mode), 24'd0);
      btn_mode = 1'b1;
      cycles(5);
      check("hold_c5_mode", 24'(set_mode), 24'd0);
      cycles(1);
      check("hold_c6_mode", 24'(set_mode), 24'd1);
      check("hold_c6_upd",  24'(update),   24'd1);
      btn_mode = 1'b0;
      cycles(6);
      check("seth_time", time_bcd, 24'h000001);

      // Hours to 05, then simultaneous mode+inc: mode wins
      press_n(1'b0, 1'b1, 5);
      check("hours05", time_bcd, 24'h050001);
`ifndef TIME_KEEPER_BLINK_EN
      check("blank_off_set", 24'(blank), 24'd0);
`endif
      press(1'b1, 1'b1);
      check("both_mode", 24'(set_mode), 24'd2);
      check("both_time", time_bcd,      24'h050001);

      // Preload 23:59:59 with field wrap checks
      do_reset();
      press(1'b1, 1'b0);
      check("pre_mode_h", 24'(set_mode), 24'd1);
      press_n(1'b0, 1'b1, 23);
      check("pre_h23", time_bcd, 24'h230000);
      press(1'b0, 1'b1);
      check("pre_h_wrap", time_bcd, 24'h000000);
      press_n(1'b0, 1'b1, 23);
      press(1'b1, 1'b0);
      check("pre_mode_m", 24'(set_mode), 24'd2);
      press_n(1'b0, 1'b1, 59);
      check("pre_m59", time_bcd, 24'h235900);
      u0 = upd_cnt;
      press(1'b0, 1'b1);
      check("m_wrap", time_bcd, 24'h230000);
`ifndef TIME_KEEPER_BLINK_EN
      check("m_wrap_upd", 24'(upd_cnt - u0), 24'd1);
`endif
      cycles(50);
      check("m_hold_time", time_bcd, 24'h230000);
`ifndef TIME_KEEPER_BLINK_EN
      check("m_hold_upd", 24'(upd_cnt - u0), 24'd1);
`endif
      press_n(1'b0, 1'b1, 59);
      press(1'b1, 1'b0);
      check("pre_mode_s", 24'(set_mode), 24'd3);
      press_n(1'b0, 1'b1, 59);
      check("pre_s59", time_bcd, 24'h235959);
      press(1'b0, 1'b1);
      check("s_wrap", time_bcd, 24'h235900);
      press_n(1'b0, 1'b1, 59);
      check("pre_final", time_bcd, 24'h235959);

      // Back to RUN: full first second, then rollover to midnight
      press(1'b1, 1'b0);
      check("run_mode", 24'(set_mode), 24'd0);
      u0 = upd_cnt;
      cycles(3);
      check("roll_c9_time", time_bcd,    24'h235959);
      check("roll_c9_upd",  24'(update), 24'd0);
      cycles(1);
      check("roll_time", time_bcd,    24'h000000);
      check("roll_upd",  24'(update), 24'd1);
      cycles(5);
      check("roll_cnt", 24'(upd_cnt - u0), 24'd1);
      check("run_blank", 24'(blank), 24'd0);

`ifdef TIME_KEEPER_BLINK_EN
      // Blink of the seconds field in SET_S
      press_n(1'b1, 1'b0, 3);
      check("blink_mode", 24'(set_mode), 24'd3);
      check("blink_p1",   24'(blank),    24'h03);
      cycles(3);
      check("blink_p1b",  24'(blank),    24'h03);
      cycles(1);
      check("blink_p0",     24'(blank),  24'h00);
      check("blink_p0_upd", 24'(update), 24'd1);
      cycles(5);
      check("blink_p1c",     24'(blank),  24'h03);
      check("blink_p1c_upd", 24'(update), 24'd1);
      press(1'b1, 1'b0);
      check("blink_run_mode",  24'(set_mode), 24'd0);
      check("blink_run_blank", 24'(blank),    24'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
